// File: rtl/interlayer_pkg.sv
// Shared definitions for the layer-4 to layer-5 ping-pong frame buffer:
// read FSM encoding and geometry helpers derived from the layer-4 width.
package interlayer_pkg;

  typedef enum logic {
    RD_IDLE   = 1'b0,
    RD_STREAM = 1'b1
  } rd_state_t;

  // Pooled (2x2 max-pool) output width.
  function automatic int calc_out_w(input int width);
    return width / 2;
  endfunction

  // Pixels per pooled frame.
  function automatic int calc_frame(input int width);
    return calc_out_w(width) * calc_out_w(width);
  endfunction

  // Address width for one frame bank, never narrower than one bit.
  function automatic int calc_addr_w(input int width);
    int frame;
    frame = calc_frame(width);
    return (frame <= 2) ? 1 : $clog2(frame);
  endfunction

endpackage

// File: rtl/interlayer_bank.sv
// One frame bank: register array with a synchronous write port and an
// asynchronous (combinational) read port. Contents are deliberately not reset.
module interlayer_bank #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 16,
  parameter int AW         = 2
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Synchronous write of one pixel.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/interlayer_frame_buffer.sv
// Ping-pong frame buffer: captures the free-running pooled pixel stream into
// two banks and replays each completed frame row-major to the next layer.
//
// Handshake: a pixel transfers on a rising edge where valid_out && ready_in.
// While ready_in is low, valid_out and data_out hold; valid_out never drops
// without a transfer. The input side has no stall: a pixel arriving while the
// target bank is still full is dropped and flagged in the sticky overflow bit.
module interlayer_frame_buffer #(
  parameter int WIDTH      = 5,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  ready_in,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  last_out,
  output logic [31:0]           counter_col,
  output logic [31:0]           counter_row,
  output logic [1:0]            bank_full,
  output logic                  overflow
);
  import interlayer_pkg::*;

  localparam int OUT_W = calc_out_w(WIDTH);
  localparam int FRAME = calc_frame(WIDTH);
  localparam int AW    = calc_addr_w(WIDTH);

  localparam logic [AW-1:0] LAST_ADDR = AW'(FRAME - 1);
  localparam logic [31:0]   LAST_COL  = 32'(OUT_W - 1);

  rd_state_t       state_q, state_d;
  logic            wr_bank_q, wr_bank_d;
  logic            rd_bank_q, rd_bank_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [AW-1:0]   rd_addr_q, rd_addr_d;
  logic [1:0]      bank_full_q, bank_full_d;
  logic            overflow_q, overflow_d;
  logic [31:0]     col_q, col_d;
  logic [31:0]     row_q, row_d;

  logic                  wr_fire, wr_drop, wr_last;
  logic                  xfer, rd_last;
  logic                  we0, we1;
  logic [DATA_WIDTH-1:0] rdata0, rdata1, rd_data;

  // Fullness is judged on pre-edge state, so a bank freed this cycle
  // still rejects a same-cycle write.
  assign wr_fire = valid_in && !bank_full_q[wr_bank_q];
  assign wr_drop = valid_in &&  bank_full_q[wr_bank_q];
  assign wr_last = wr_fire && (wr_addr_q == LAST_ADDR);
  assign xfer    = (state_q == RD_STREAM) && ready_in;
  assign rd_last = xfer && (rd_addr_q == LAST_ADDR);

  assign we0 = wr_fire && !wr_bank_q;
  assign we1 = wr_fire &&  wr_bank_q;

  interlayer_bank #(.DEPTH(FRAME), .DATA_WIDTH(DATA_WIDTH), .AW(AW)) u_bank0 (
    .clk(clk), .we(we0), .waddr(wr_addr_q), .wdata(data_in),
    .raddr(rd_addr_q), .rdata(rdata0)
  );

  interlayer_bank #(.DEPTH(FRAME), .DATA_WIDTH(DATA_WIDTH), .AW(AW)) u_bank1 (
    .clk(clk), .we(we1), .waddr(wr_addr_q), .wdata(data_in),
    .raddr(rd_addr_q), .rdata(rdata1)
  );

  assign rd_data = rd_bank_q ? rdata1 : rdata0;

  // Write pointer, bank flags and sticky overflow.
  always_comb begin
    wr_bank_d   = wr_bank_q;
    wr_addr_d   = wr_addr_q;
    bank_full_d = bank_full_q;
    overflow_d  = overflow_q || wr_drop;
    if (wr_fire) begin
      if (wr_last) begin
        wr_addr_d              = '0;
        wr_bank_d              = !wr_bank_q;
        bank_full_d[wr_bank_q] = 1'b1;
      end else begin
        wr_addr_d = wr_addr_q + 1'b1;
      end
    end
    // A write only completes into an empty bank and a read only completes
    // out of a full one, so these never target the same bank.
    if (rd_last) begin
      bank_full_d[rd_bank_q] = 1'b0;
    end
  end

  // Read FSM next state plus read address and output coordinates.
  always_comb begin
    state_d   = state_q;
    rd_bank_d = rd_bank_q;
    rd_addr_d = rd_addr_q;
    col_d     = col_q;
    row_d     = row_q;
    case (state_q)
      RD_IDLE: begin
        if (bank_full_q[rd_bank_q]) state_d = RD_STREAM;
      end
      RD_STREAM: begin
        if (rd_last) begin
          state_d   = RD_IDLE;
          rd_bank_d = !rd_bank_q;
          rd_addr_d = '0;
          col_d     = '0;
          row_d     = '0;
        end else if (xfer) begin
          rd_addr_d = rd_addr_q + 1'b1;
          if (col_q == LAST_COL) begin
            col_d = '0;
            row_d = row_q + 32'd1;
          end else begin
            col_d = col_q + 32'd1;
          end
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

  // State register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RD_IDLE;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_addr_q   <= '0;
      rd_addr_q   <= '0;
      bank_full_q <= 2'b00;
      overflow_q  <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
    end else begin
      state_q     <= state_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      wr_addr_q   <= wr_addr_d;
      rd_addr_q   <= rd_addr_d;
      bank_full_q <= bank_full_d;
      overflow_q  <= overflow_d;
      col_q       <= col_d;
      row_q       <= row_d;
    end
  end

  assign valid_out   = (state_q == RD_STREAM);
  assign data_out    = valid_out ? rd_data : '0;
  assign last_out    = valid_out && (rd_addr_q == LAST_ADDR);
  assign counter_col = col_q;
  assign counter_row = row_q;
  assign bank_full   = bank_full_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_interlayer_frame_buffer.sv
// Directed bench for interlayer_frame_buffer with WIDTH=5 (2x2 frames of 4).
// Inputs change on the falling edge; outputs are sampled on the falling edge
// before inputs are updated.
module tb_interlayer_frame_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [15:0] data_in;
  logic        ready_in;
  logic        valid_out;
  logic [15:0] data_out;
  logic        last_out;
  logic [31:0] counter_col;
  logic [31:0] counter_row;
  logic [1:0]  bank_full;
  logic        overflow;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  interlayer_frame_buffer #(.WIDTH(5), .DATA_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in),
    .ready_in(ready_in), .valid_out(valid_out), .data_out(data_out),
    .last_out(last_out), .counter_col(counter_col), .counter_row(counter_row),
    .bank_full(bank_full), .overflow(overflow)
  );

  task automatic do_reset();
    rst = 1'b1; valid_in = 1'b0; data_in = '0; ready_in = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid_in = 1'b0; data_in = '0; ready_in = 1'b0;
    #1;
    tests++; if (valid_out !== 1'b0) begin fails++; $display("FAIL reset_valid_out: got %0b want 0", valid_out); end
    tests++; if (last_out !== 1'b0) begin fails++; $display("FAIL reset_last_out: got %0b want 0", last_out); end
    tests++; if (data_out !== 16'd0) begin fails++; $display("FAIL reset_data_out: got %0d want 0", data_out); end
    tests++; if (counter_col !== 32'd0) begin fails++; $display("FAIL reset_col: got %0d want 0", counter_col); end
    tests++; if (counter_row !== 32'd0) begin fails++; $display("FAIL reset_row: got %0d want 0", counter_row); end
    tests++; if (bank_full !== 2'b00) begin fails++; $display("FAIL reset_bank_full: got %b want 00", bank_full); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow: got %0b want 0", overflow); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_frame();
    logic exp_last;
    do_reset();
    ready_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); valid_in = 1'b1; data_in = 16'(i + 1);
    end
    @(negedge clk); valid_in = 1'b0;
    tests++; if (bank_full !== 2'b01) begin fails++; $display("FAIL single_full_after_write: got %b want 01", bank_full); end
    tests++; if (valid_out !== 1'b0) begin fails++; $display("FAIL single_latency: valid_out got %0b want 0 one cycle after last write", valid_out); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      exp_last = (k == 3);
      tests++; if (valid_out !== 1'b1) begin fails++; $display("FAIL single_valid[%0d]: got %0b want 1", k, valid_out); end
      tests++; if (data_out !== 16'(k + 1)) begin fails++; $display("FAIL single_data[%0d]: got %0d want %0d", k, data_out, k + 1); end
      tests++; if (counter_col !== 32'(k % 2)) begin fails++; $display("FAIL single_col[%0d]: got %0d want %0d", k, counter_col, k % 2); end
      tests++; if (counter_row !== 32'(k / 2)) begin fails++; $display("FAIL single_row[%0d]: got %0d want %0d", k, counter_row, k / 2); end
      tests++; if (last_out !== exp_last) begin fails++; $display("FAIL single_last[%0d]: got %0b want %0b", k, last_out, exp_last); end
    end
    @(negedge clk);
    tests++; if (valid_out !== 1'b0) begin fails++; $display("FAIL single_end_valid: got %0b want 0", valid_out); end
    tests++; if (bank_full !== 2'b00) begin fails++; $display("FAIL single_end_full: got %b want 00", bank_full); end
  endtask

  task automatic test_backpressure();
    logic exp_last;
    do_reset();
    ready_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); valid_in = 1'b1; data_in = 16'(i + 1);
    end
    @(negedge clk); valid_in = 1'b0;
    @(negedge clk);
    tests++; if (valid_out !== 1'b1 || data_out !== 16'd1) begin fails++; $display("FAIL bp_first: valid %0b data %0d want 1/1", valid_out, data_out); end
    ready_in = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      tests++; if (valid_out !== 1'b1 || data_out !== 16'd1 || counter_col !== 32'd0) begin
        fails++; $display("FAIL bp_hold[%0d]: valid %0b data %0d col %0d want 1/1/0", j, valid_out, data_out, counter_col);
      end
    end
    ready_in = 1'b1;
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      exp_last = (k == 3);
      tests++; if (valid_out !== 1'b1 || data_out !== 16'(k + 1)) begin fails++; $display("FAIL bp_resume[%0d]: valid %0b data %0d want 1/%0d", k, valid_out, data_out, k + 1); end
      tests++; if (last_out !== exp_last) begin fails++; $display("FAIL bp_last[%0d]: got %0b want %0b", k, last_out, exp_last); end
    end
    @(negedge clk);
    tests++; if (valid_out !== 1'b0) begin fails++; $display("FAIL bp_end_valid: got %0b want 0", valid_out); end
  endtask

  task automatic test_back_to_back();
    logic exp_v, exp_last;
    int   exp_d, idx;
    do_reset();
    ready_in = 1'b1;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (c >= 4) begin
        exp_v    = (c >= 5 && c <= 8) || (c >= 10 && c <= 13);
        exp_d    = (c <= 8) ? c - 4 : c - 5;
        idx      = (c <= 8) ? c - 5 : c - 10;
        exp_last = (c == 8) || (c == 13);
        tests++; if (valid_out !== exp_v) begin fails++; $display("FAIL pp_valid[c%0d]: got %0b want %0b", c, valid_out, exp_v); end
        if (exp_v) begin
          tests++; if (data_out !== 16'(exp_d)) begin fails++; $display("FAIL pp_data[c%0d]: got %0d want %0d", c, data_out, exp_d); end
          tests++; if (counter_col !== 32'(idx % 2) || counter_row !== 32'(idx / 2)) begin
            fails++; $display("FAIL pp_coord[c%0d]: got (%0d,%0d) want (%0d,%0d)", c, counter_col, counter_row, idx % 2, idx / 2);
          end
          tests++; if (last_out !== exp_last) begin fails++; $display("FAIL pp_last[c%0d]: got %0b want %0b", c, last_out, exp_last); end
        end
      end
      if (c < 8) begin valid_in = 1'b1; data_in = 16'(c + 1); end
      else valid_in = 1'b0;
    end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL pp_overflow: got %0b want 0", overflow); end
    tests++; if (bank_full !== 2'b00) begin fails++; $display("FAIL pp_end_full: got %b want 00", bank_full); end
  endtask

  task automatic test_overflow();
    logic exp_v;
    int   exp_d;
    do_reset();
    ready_in = 1'b0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk); valid_in = 1'b1; data_in = 16'(c + 1);
    end
    @(negedge clk); valid_in = 1'b0;
    tests++; if (bank_full !== 2'b11) begin fails++; $display("FAIL ovf_full: got %b want 11", bank_full); end
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_flag: got %0b want 1", overflow); end
    tests++; if (valid_out !== 1'b1 || data_out !== 16'd1) begin fails++; $display("FAIL ovf_hold: valid %0b data %0d want 1/1", valid_out, data_out); end
    ready_in = 1'b1;
    for (int c = 10; c < 19; c++) begin
      @(negedge clk);
      exp_v = (c != 13) && (c != 18);
      exp_d = (c < 13) ? c - 8 : c - 9;
      tests++; if (valid_out !== exp_v) begin fails++; $display("FAIL ovf_valid[c%0d]: got %0b want %0b", c, valid_out, exp_v); end
      if (exp_v) begin
        tests++; if (data_out !== 16'(exp_d)) begin fails++; $display("FAIL ovf_data[c%0d]: got %0d want %0d", c, data_out, exp_d); end
      end
    end
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky: got %0b want 1", overflow); end
    tests++; if (bank_full !== 2'b00) begin fails++; $display("FAIL ovf_end_full: got %b want 00", bank_full); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    ready_in = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 8) begin
        tests++; if (bank_full !== 2'b01) begin fails++; $display("FAIL sim_pre_full: got %b want 01", bank_full); end
        tests++; if (last_out !== 1'b1 || data_out !== 16'd4) begin fails++; $display("FAIL sim_pre_last: last %0b data %0d want 1/4", last_out, data_out); end
      end
      if (c == 9) begin
        tests++; if (bank_full !== 2'b10) begin fails++; $display("FAIL sim_post_full: got %b want 10", bank_full); end
        tests++; if (valid_out !== 1'b0) begin fails++; $display("FAIL sim_idle_gap: valid_out got %0b want 0", valid_out); end
      end
      valid_in = (c < 4) || (c >= 5 && c <= 8);
      data_in  = (c < 4) ? 16'(c + 1) : 16'(c);
    end
    for (int c = 10; c < 14; c++) begin
      @(negedge clk);
      tests++; if (valid_out !== 1'b1 || data_out !== 16'(c - 5)) begin
        fails++; $display("FAIL sim_bank1[c%0d]: valid %0b data %0d want 1/%0d", c, valid_out, data_out, c - 5);
      end
    end
    @(negedge clk);
    tests++; if (bank_full !== 2'b00 || valid_out !== 1'b0) begin fails++; $display("FAIL sim_end: full %b valid %0b want 00/0", bank_full, valid_out); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    ready_in = 1'b0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk); valid_in = 1'b1; data_in = 16'(c + 1);
    end
    @(negedge clk); valid_in = 1'b0; ready_in = 1'b1;
    repeat (2) @(negedge clk);
    tests++; if (data_out !== 16'd3 || counter_row !== 32'd1 || overflow !== 1'b1) begin
      fails++; $display("FAIL rmid_pre: data %0d row %0d ovf %0b want 3/1/1", data_out, counter_row, overflow);
    end
    #2 rst = 1'b1;
    #1;
    tests++; if (valid_out !== 1'b0) begin fails++; $display("FAIL rmid_valid: got %0b want 0", valid_out); end
    tests++; if (data_out !== 16'd0) begin fails++; $display("FAIL rmid_data: got %0d want 0", data_out); end
    tests++; if (counter_col !== 32'd0 || counter_row !== 32'd0) begin fails++; $display("FAIL rmid_counters: got (%0d,%0d) want (0,0)", counter_col, counter_row); end
    tests++; if (bank_full !== 2'b00) begin fails++; $display("FAIL rmid_full: got %b want 00", bank_full); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL rmid_overflow: got %0b want 0", overflow); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); valid_in = 1'b1; data_in = 16'(10 + i);
    end
    @(negedge clk); valid_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      tests++; if (valid_out !== 1'b1 || data_out !== 16'(10 + k)) begin
        fails++; $display("FAIL rmid_stream[%0d]: valid %0b data %0d want 1/%0d", k, valid_out, data_out, 10 + k);
      end
      tests++; if (counter_col !== 32'(k % 2) || counter_row !== 32'(k / 2)) begin
        fails++; $display("FAIL rmid_coord[%0d]: got (%0d,%0d) want (%0d,%0d)", k, counter_col, counter_row, k % 2, k / 2);
      end
    end
    @(negedge clk);
    tests++; if (valid_out !== 1'b0 || bank_full !== 2'b00) begin fails++; $display("FAIL rmid_end: valid %0b full %b want 0/00", valid_out, bank_full); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_backpressure();
    test_back_to_back();
    test_overflow();
    test_simultaneous();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete within 100000 time units");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/interlayer_frame_buffer.md
# interlayer_frame_buffer

Ping-pong frame buffer between the layer-4 max-pooling output and the layer-5 input control. Captures the free-running pooled pixel stream (one pixel per `valid_in`, no upstream stall) into one of two frame banks. Replays each completed frame row-major to the next layer under a valid/ready handshake, so layer 5 can stall without losing layer-4 output.

## Interface
Parameters:
- `WIDTH`, 5, input feature-map width of layer 4; pooled width `OUT_W = WIDTH/2` (integer division)
- `DATA_WIDTH`, 16, pixel width
- Derived constant: `FRAME = OUT_W*OUT_W`, pixels per frame

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `valid_in`  in  1  pooled pixel present this cycle (max-pooling `valid_out`)
- `data_in`  in  DATA_WIDTH  pooled pixel
- `ready_in`  in  1  downstream accepts `data_out` this cycle
- `valid_out`  out  1  `data_out` holds a valid pixel
- `data_out`  out  DATA_WIDTH  current output pixel
- `last_out`  out  1  `data_out` is pixel FRAME-1 of its frame
- `counter_col`  out  32  column of current output pixel
- `counter_row`  out  32  row of current output pixel
- `bank_full`  out  2  per-bank frame-complete flags
- `overflow`  out  1  sticky; a pixel was dropped

## Operation
- Reset (async): `wr_bank=0`, `rd_bank=0`, `wr_addr=0`, `rd_addr=0`, `bank_full=2'b00`, read FSM=IDLE, `overflow=0`. Outputs: `valid_out=0`, `last_out=0`, `counter_col=0`, `counter_row=0`, `data_out=0`. Bank contents are not reset.
- Write side: on `valid_in` with `bank_full[wr_bank]==0`, write `data_in` to `bank[wr_bank][wr_addr]` and increment `wr_addr`. When `wr_addr==FRAME-1`, the write also sets `bank_full[wr_bank]`, toggles `wr_bank`, and sets `wr_addr=0`.
- Write into a full bank: `valid_in` with `bank_full[wr_bank]==1` drops the pixel. Set `overflow`, which stays 1 until reset. `wr_addr` and `wr_bank` do not change.
- Read FSM states:
  - IDLE: go to STREAM when `bank_full[rd_bank]`.
  - STREAM: `valid_out=1`. `data_out = bank[rd_bank][rd_addr]`, read combinationally from the register array.
- Transfer occurs when `valid_out && ready_in`. On a transfer, `rd_addr` increments, and `counter_col` increments, wrapping at OUT_W-1 to 0 with `counter_row` incrementing.
- Last transfer (`rd_addr==FRAME-1`): clear `bank_full[rd_bank]`, toggle `rd_bank`, reset `rd_addr`/`counter_col`/`counter_row` to 0, go to IDLE.
- `last_out = valid_out && rd_addr==FRAME-1`.
- `valid_out` and `data_out` stay stable while `ready_in==0`.
- Same-cycle write-complete and read-complete on different banks: both flag updates apply, set on one bank and clear on the other.
- Same-cycle read-complete of bank B and a `valid_in` to bank B (B was full): the write is dropped and `overflow` is set, because fullness is evaluated on pre-edge state.
- Counter arithmetic is unsigned. Address widths are `$clog2(FRAME)`, minimum 1.

## Timing
- Final write of a frame at edge t: `bank_full` is set after t. FSM enters STREAM at t+1, so `valid_out` is high in the cycle after edge t+1. First-pixel latency from the final `valid_in` is 2 cycles.
- Minimum frame-to-frame read spacing: FRAME transfers plus 1 IDLE cycle.
- With `ready_in` held at 1, each frame streams in FRAME consecutive cycles.
- Steady state without overflow requires average read throughput ≥ write rate. One full frame of slack is available.
- Reset mid-stream aborts the frame. Outputs return to reset values asynchronously.

## Structure
- Shared package `interlayer_pkg`: read FSM state encoding (IDLE, STREAM), and a function computing OUT_W/FRAME/address width from WIDTH.
- Sub-module `interlayer_bank`: one FRAME×DATA_WIDTH register array with a synchronous write port and an async read port. Instantiated twice.
- Top level holds the write pointer, the read FSM, the flags and the counters.

## Test plan
All scenarios use WIDTH=5 (OUT_W=2, FRAME=4), DATA_WIDTH=16.
- Single frame: `valid_in` for 4 cycles with data 1,2,3,4 and `ready_in=1`. Output is 1,2,3,4 with `valid_out` first high 2 cycles after the 4th write. (col,row) = (0,0),(1,0),(0,1),(1,1). `last_out` is high only on 4. `bank_full` returns to 00.
- Backpressure: same frame with `ready_in` low for 3 cycles after the first output. `data_out` holds 1 with `valid_out=1` throughout. The stream resumes 2,3,4 with no loss.
- Ping-pong: 8 consecutive `valid_in` (1..8) with `ready_in=1`. Output is 1..8 in order with one IDLE gap between frames. `overflow=0`.
- Overflow: `ready_in=0`, 9 `valid_in` (1..9). `bank_full=11`, `overflow=1`, pixel 9 is dropped. After releasing `ready_in`, output is 1..8 and `overflow` stays 1.
- Simultaneous completion: bank 1's final write coincides with bank 0's last transfer. After the edge, `bank_full=10` and the read moves to bank 1.
- Reset mid-stream: assert `rst` after 2 outputs. `valid_out`, counters, `bank_full` and `overflow` go to 0 immediately. A following 4-pixel frame streams correctly from bank 0.
